fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Parametrised write-side controller for the synchronous FIFO. It supersedes the fixed 5-bit write pointer and works for any power-of-two depth. It generates the write pointer, RAM write address, write enable, full and almost-full flags, and fill level, plus a sticky overflow flag for writes dropped while full. It sits between the producer interface and the dual-port RAM, and receives the read pointer from the read-side controller in the same clock domain.

Parameters:
ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W entries (legal 2..10)
AFULL_THRESH, 12, level at or above which fifo_afull asserts (legal 1..DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
wr  in  1  producer write request
rptr  in  ADDR_W+1  binary read pointer from the read-side controller (wrap bit in MSB)
ovf_clr  in  1  clear request for ovf_sticky
wptr  out  ADDR_W+1  binary write pointer, registered
waddr  out  ADDR_W  RAM write address = wptr[ADDR_W-1:0]
fifo_we  out  1  RAM write enable
fifo_full  out  1  FIFO full
fifo_afull  out  1  level >= AFULL_THRESH
fifo_level  out  ADDR_W+1  entries occupied, 0..DEPTH
ovf_sticky  out  1  a write was dropped while full, registered

Behaviour:
- Reset (rst_n low, asynchronous): wptr = 0, ovf_sticky = 0, wptr_gray = 0 when present. Combinational outputs follow from these values.
- level = (wptr - rptr) mod 2^(ADDR_W+1). fifo_level = level.
- fifo_full = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]); this is equivalent to level == DEPTH.
- fifo_afull = (level >= AFULL_THRESH). It is combinational, with no hysteresis.
- fifo_we = wr & ~fifo_full. It is combinational, with zero latency from wr, so the RAM writes waddr on the same edge that the pointer advances.
- Pointer update on the rising edge: if fifo_we, wptr <= wptr + 1, with natural wrap at 2^(ADDR_W+1). Otherwise wptr holds.
- Wrap-around: from wptr = 2*DEPTH-1, the next value is 0. The MSB toggles each time the address wraps.
- Simultaneous read and write while full: the write is refused (fifo_full is already high), and the read frees a slot on the next cycle. The write side does not look ahead at the read.
- Overflow: on an edge with wr & fifo_full, ovf_sticky <= 1. On an edge with ovf_clr and no overflow event, ovf_sticky <= 0. If set and clear occur together, set wins.
- rptr is assumed to be a legal pointer (level <= DEPTH). For an illegal rptr the flags are undefined; no checking is done in RTL.
- Reset mid-operation: all state returns to zero immediately. In-flight writes are lost, and no fifo_we pulse follows reset release unless wr is high and the FIFO is not full.

Optional Feature:
Macro FIFO_WPTR_GRAY_EN.
- Defined: adds output port wptr_gray [ADDR_W:0], registered. On each fifo_we edge it loads gray(wptr+1), where gray(x) = x ^ (x>>1). It therefore always equals gray(wptr) and is glitch-free for a future asynchronous clock-domain-crossing read side. Reset value is 0.
- Undefined: the port and its register are absent, and all other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - the ptr_t width convention (ADDR_W+1);
  - the function bin2gray;
  - the localparam DEPTH derivation.
- One sub-module is natural: fifo_flag_gen. It is purely combinational, takes wptr and rptr as inputs, and produces level, full and afull. The read-side controller can reuse it for its empty flag.

Test Plan:
- Reset: rst_n low while wr=1 -> wptr=0, fifo_we=1 (rptr=0, not full), ovf_sticky=0. Release rst_n -> wptr increments to 1 on the first edge.
- Fill (ADDR_W=4, rptr held at 0): 16 writes -> wptr=16 (5'b10000), fifo_full=1, fifo_level=16, fifo_afull first high when level=12.
- Overflow: with the FIFO full, pulse wr for 1 cycle -> fifo_we=0, wptr stays 16, ovf_sticky=1 on the next cycle. Then ovf_clr=1 together with wr=1 while still full -> ovf_sticky stays 1 (set wins). Then ovf_clr alone -> ovf_sticky=0.
- Wrap: start at wptr=31 with rptr=16, then write -> wptr=0, waddr=0, fifo_level=16, fifo_full=1.
- Concurrent read and write: with the FIFO full, advance rptr by 1 while wr=1 -> no write that cycle, fifo_we=1 the next cycle, level returns to 16.
- Gray (with FIFO_WPTR_GRAY_EN): write continuously for 32 cycles -> wptr_gray == wptr ^ (wptr>>1) every cycle, exactly 1 bit changes per write, and the value returns to 0 after the wrap.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: pointer width, depth and Gray coding.
package fifo_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned MAX_PTR_W  = 11;

  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 1 << addr_w;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// Combinational occupancy flags from a write/read pointer pair; shared by both FIFO sides.
module fifo_flag_gen
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic [ADDR_W:0] wptr,
  input  logic [ADDR_W:0] rptr,
  output logic [ADDR_W:0] level,
  output logic            full,
  output logic            afull
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam int unsigned THRESH_INT =
    (AFULL_THRESH > int'(DEPTH)) ? DEPTH : AFULL_THRESH;
  localparam logic [ADDR_W:0] THRESH = (ADDR_W+1)'(THRESH_INT);

  // Modular subtraction handles the wrap bit without special cases.
  assign level = wptr - rptr;
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign afull = (level >= THRESH);

endmodule

// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side controller: pointer, RAM write enable, flags and sticky overflow.
// Define FIFO_WPTR_GRAY_EN to add a registered Gray-coded copy of the write pointer.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W:0]   rptr,
  input  logic              ovf_clr,
  output logic [ADDR_W:0]   wptr,
  output logic [ADDR_W-1:0] waddr,
  output logic              fifo_we,
  output logic              fifo_full,
  output logic              fifo_afull,
  output logic [ADDR_W:0]   fifo_level,
  output logic              ovf_sticky
`ifdef FIFO_WPTR_GRAY_EN
  ,
  output logic [ADDR_W:0]   wptr_gray
`endif
);

  localparam int PW = ptr_w(ADDR_W);

  logic [PW-1:0] wptr_next;

  assign wptr_next = wptr + PW'(1);
  assign waddr     = wptr[ADDR_W-1:0];
  // Zero-latency enable: the RAM writes waddr on the same edge the pointer moves.
  assign fifo_we   = wr & ~fifo_full;

  fifo_flag_gen #(
    .ADDR_W       (ADDR_W),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_flags (
    .wptr  (wptr),
    .rptr  (rptr),
    .level (fifo_level),
    .full  (fifo_full),
    .afull (fifo_afull)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (fifo_we) wptr <= wptr_next;
      // A fresh overflow beats a simultaneous clear.
      if (wr & fifo_full)  ovf_sticky <= 1'b1;
      else if (ovf_clr)    ovf_sticky <= 1'b0;
    end
  end

`ifdef FIFO_WPTR_GRAY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wptr_gray <= '0;
    else if (fifo_we) wptr_gray <= PW'(bin2gray(ptr_max_t'(wptr_next)));
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with an occupancy-count reference model.
module tb_fifo_wr_ctrl;

  localparam int ADDR_W = 4;
  localparam int THRESH = 12;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MODV   = 2 * DEPTH;

  logic              clk;
  logic              rst_n;
  logic              wr;
  logic [ADDR_W:0]   rptr;
  logic              ovf_clr;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W-1:0] waddr;
  logic              fifo_we;
  logic              fifo_full;
  logic              fifo_afull;
  logic [ADDR_W:0]   fifo_level;
  logic              ovf_sticky;
`ifdef FIFO_WPTR_GRAY_EN
  logic [ADDR_W:0]   wptr_gray;
`endif

  int checks   = 0;
  int failures = 0;

  fifo_wr_ctrl #(
    .ADDR_W       (ADDR_W),
    .AFULL_THRESH (THRESH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr),
    .rptr       (rptr),
    .ovf_clr    (ovf_clr),
    .wptr       (wptr),
    .waddr      (waddr),
    .fifo_we    (fifo_we),
    .fifo_full  (fifo_full),
    .fifo_afull (fifo_afull),
    .fifo_level (fifo_level),
    .ovf_sticky (ovf_sticky)
`ifdef FIFO_WPTR_GRAY_EN
    ,
    .wptr_gray  (wptr_gray)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: count of accepted writes, modulo twice the depth
  int m_wptr = 0;
  int m_ovf  = 0;

  function automatic int m_level();
    return (m_wptr - int'(rptr) + MODV) % MODV;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wptr = 0;
      m_ovf  = 0;
    end else begin
      int lv;
      lv = m_level();
      if (wr && lv != DEPTH) m_wptr = (m_wptr + 1) % MODV;
      if (wr && lv == DEPTH) m_ovf = 1;
      else if (ovf_clr)      m_ovf = 0;
    end
  end

  // compare process
  always @(negedge clk) begin
    int lv;
    lv = m_level();
    chk("wptr",  int'(wptr),       m_wptr);
    chk("waddr", int'(waddr),      m_wptr % DEPTH);
    chk("level", int'(fifo_level), lv);
    chk("full",  int'(fifo_full),  int'(lv == DEPTH));
    chk("afull", int'(fifo_afull), int'(lv >= THRESH));
    chk("we",    int'(fifo_we),    int'(wr && lv != DEPTH));
    chk("ovf",   int'(ovf_sticky), m_ovf);
`ifdef FIFO_WPTR_GRAY_EN
    chk("gray",  int'(wptr_gray),  m_wptr ^ (m_wptr >> 1));
`endif
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
`ifdef FIFO_WPTR_GRAY_EN
    logic [ADDR_W:0] prev_gray;
`endif
    rst_n = 1'b0; wr = 1'b1; rptr = '0; ovf_clr = 1'b0;

    // reset with write requested
    tick; tick;
    chk("rst_wptr", int'(wptr), 0);
    chk("rst_we",   int'(fifo_we), 1);
    chk("rst_ovf",  int'(ovf_sticky), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("rel_wptr", int'(wptr), 1);

    // fill with rptr held at 0
    for (int i = 2; i <= 16; i++) begin
      tick;
      chk("fill_wptr",  int'(wptr), i);
      chk("fill_level", int'(fifo_level), i);
      chk("fill_afull", int'(fifo_afull), int'(i >= 12));
    end
    wr = 1'b0;
    #1;
    chk("fill_full", int'(fifo_full), 1);
    chk("fill_we",   int'(fifo_we), 0);

    // overflow, set-wins, clear
    wr = 1'b1;
    #1;
    chk("ovf_we_blocked", int'(fifo_we), 0);
    tick;
    wr = 1'b0;
    chk("ovf_wptr_hold", int'(wptr), 16);
    chk("ovf_set", int'(ovf_sticky), 1);
    wr = 1'b1; ovf_clr = 1'b1;
    tick;
    chk("ovf_set_wins", int'(ovf_sticky), 1);
    wr = 1'b0;
    tick;
    chk("ovf_clear", int'(ovf_sticky), 0);
    ovf_clr = 1'b0;

    // read and write together while full
    wr = 1'b1;
    #1;
    chk("rw_we_refused", int'(fifo_we), 0);
    tick;
    rptr = 5'd1;
    #1;
    chk("rw_wptr_hold", int'(wptr), 16);
    chk("rw_level", int'(fifo_level), 15);
    chk("rw_we_next", int'(fifo_we), 1);
    tick;
    chk("rw_wptr", int'(wptr), 17);
    chk("rw_level_back", int'(fifo_level), 16);
    chk("rw_full", int'(fifo_full), 1);
    wr = 1'b0; ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    chk("rw_ovf_cleared", int'(ovf_sticky), 0);

    // wrap from 31 to 0 with rptr at 16
    rptr = 5'd16; wr = 1'b1;
    repeat (14) tick;
    chk("wrap_pre", int'(wptr), 31);
    tick;
    wr = 1'b0;
    chk("wrap_wptr",  int'(wptr), 0);
    chk("wrap_waddr", int'(waddr), 0);
    chk("wrap_level", int'(fifo_level), 16);
    chk("wrap_full",  int'(fifo_full), 1);

    // asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wptr", int'(wptr), 0);
    chk("mid_rst_ovf",  int'(ovf_sticky), 0);
    rptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("mid_rst_no_we", int'(wptr), 0);

    // continuous writes through a full wrap, reader keeps up
    wr = 1'b1; cnt = 0;
`ifdef FIFO_WPTR_GRAY_EN
    prev_gray = wptr_gray;
`endif
    for (int i = 0; i < 32; i++) begin
      tick;
      cnt = (cnt + 1) % MODV;
      rptr = 5'(cnt);
      chk("run_wptr", int'(wptr), cnt);
`ifdef FIFO_WPTR_GRAY_EN
      chk("run_gray_bits", $countones(wptr_gray ^ prev_gray), 1);
      prev_gray = wptr_gray;
`endif
    end
    wr = 1'b0;
    chk("run_end_wptr", int'(wptr), 0);
`ifdef FIFO_WPTR_GRAY_EN
    chk("run_end_gray", int'(wptr_gray), 0);
`endif

    tick; tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
